seq_accum_responder: RTL and testbench
======================================

# seq_accum_responder

Responder-side accumulator for the beat-qualified data protocol: on a start pulse it clears an internal sum, adds `data_in` on each of `BEATS` valid beats, signals completion one cycle later and presents the total on a valid/ready result port. It is the design-side producer of the `data_out == accumulated sum` relationship that the team's local-variable SVA checks. It sits between the stimulus/data source and any result consumer in the assertion example benches.

## Interface
- `DW`, 32, width of `data_in`, the internal accumulator and `result`.
- `BEATS`, 2, number of valid beats accumulated per transaction; legal range 1..255.
- `clk` input 1: single clock, all state on its rising edge.
- `rst_n` input 1: reset, asynchronous and active-low.
- `start` input 1: transaction request, sampled only in IDLE.
- `clear` input 1: synchronous abort to IDLE from any state.
- `data_in` input DW: beat operand.
- `data_valid` input 1: qualifies `data_in` in ACCUM.
- `busy` output 1: high in ACCUM, DONE and HOLD.
- `done` output 1: one-cycle pulse in DONE.
- `result` output DW: accumulated sum, stable while `result_valid`.
- `result_valid` output 1: high in HOLD.
- `result_ready` input 1: consumer accept.

## Operation
- States: IDLE, ACCUM, DONE, HOLD (encoded as `accum_state_e`).
- IDLE: `start`=1 → ACCUM; accumulator and beat counter load 0.
- ACCUM: `data_valid`=1 adds `data_in` and increments the counter; `data_valid`=0 holds both. The beat that brings the counter to `BEATS` → DONE.
- DONE: `done`=1 for exactly one cycle; `result` loads the accumulator; → HOLD.
- HOLD: `result_valid`=1; `result_valid && result_ready` → IDLE. `result` and `result_valid` stay constant until accepted.
- Arithmetic: sum is DW bits, wraps modulo 2^DW; no carry-out.
- `start` outside IDLE is ignored (no queuing).
- `clear`=1 in any state → IDLE next cycle; `done`, `result_valid`, accumulator and counter go to 0; `clear` has priority over `start`, `data_valid` and `result_ready` in the same cycle.
- `rst_n` low mid-transaction: immediate return to IDLE, partial sum discarded.

## Timing
- Reset values: `busy`=0, `done`=0, `result`=0, `result_valid`=0; state IDLE.
- Start at edge N → `busy`=1 from N+1; first beat can be accepted at edge N+1.
- Last valid beat at edge M → `done`=1 during cycle M+1, `result_valid`=1 from M+2.
- Minimum latency start→`result_valid` with back-to-back beats: `BEATS`+2 cycles.
- Accept at edge K → IDLE at K+1; next `start` earliest at K+1 (one dead cycle between transactions).

## Configuration
- `SEQ_ACCUM_SVA_EN` defined: the `seq_accum_responder_sva` checker is bound in. Using sequence local variables, it checks that `result` equals the sum of the `BEATS` valid `data_in` values captured since `start`, that `done` is exactly one cycle wide, and that `result` is stable while `result_valid && !result_ready`. Failures report through `$error`.
- Not defined: no assertion logic is compiled, and RTL behaviour is identical.

## Structure
- Package `seq_accum_pkg`: `accum_state_e` enum, `DW_DEFAULT`=32, `BEATS_DEFAULT`=2, and a counter-width localparam rule, `$clog2(BEATS+1)`.
- Sub-module: `seq_accum_responder_sva`, a checker module attached by `bind` under `SEQ_ACCUM_SVA_EN`. The datapath stays in one module.

## Test plan
- Basic: BEATS=2, start, beats 1,1 back-to-back → `done` at cycle 4, `result`=2 at cycle 5, accepted at cycle 5.
- Gapped beats: `data_valid` pattern 1,0,0,1 with data 5,x,x,7 → `result`=12. Cycles with `data_valid`=0 add nothing.
- Backpressure: hold `result_ready`=0 for 6 cycles → `result_valid`/`result` stable, `busy`=1, no second `done`; accept then IDLE.
- Wrap: DW=8, beats 0xF0 and 0x20 → `result`=0x10.
- Abort: `clear` after first beat, then `start` with beats 3,4 → `result`=7, no stale sum. Repeat with `rst_n` pulsed low mid-ACCUM → all outputs 0 immediately.
- Ignored start: `start`=1 throughout ACCUM and HOLD → exactly one transaction, next starts the cycle after accept.

Source files
------------

// File: rtl/seq_accum_pkg.sv
// Shared types and sizing rules for the beat-qualified accumulator.
package seq_accum_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2,
        HOLD  = 2'd3
    } accum_state_e;

    localparam int DW_DEFAULT    = 32;
    localparam int BEATS_DEFAULT = 2;

    // The beat counter must be able to hold the value BEATS itself.
    function automatic int cnt_w(input int beats);
        return $clog2(beats + 1);
    endfunction

endpackage

// File: rtl/seq_accum_responder_sva.sv
// Protocol checker for seq_accum_responder; compiled only with SEQ_ACCUM_SVA_EN.
`ifdef SEQ_ACCUM_SVA_EN
module seq_accum_responder_sva #(
    parameter int DW    = 32,
    parameter int BEATS = 2
) (
    input logic          clk,
    input logic          rst_n,
    input logic          start,
    input logic          clear,
    input logic [DW-1:0] data_in,
    input logic          data_valid,
    input logic          busy,
    input logic          done,
    input logic [DW-1:0] result,
    input logic          result_valid,
    input logic          result_ready
);

    // Sum of the valid beats since start must appear on result after done.
    property p_sum;
        logic [DW-1:0] s;
        @(posedge clk) disable iff (!rst_n || clear)
        (!busy && start, s = '0) ##1
        ((!data_valid)[*0:$] ##1 (data_valid, s = s + data_in))[*BEATS]
        |=> done ##1 (result == s);
    endproperty

    property p_done_one;
        @(posedge clk) disable iff (!rst_n) done |=> !done;
    endproperty

    property p_hold_stable;
        @(posedge clk) disable iff (!rst_n)
        (result_valid && !result_ready && !clear) |=> (result_valid && $stable(result));
    endproperty

    a_sum:    assert property (p_sum)         else $error("sva: result != accumulated sum");
    a_done:   assert property (p_done_one)    else $error("sva: done wider than one cycle");
    a_stable: assert property (p_hold_stable) else $error("sva: result changed under backpressure");

endmodule
`endif

// File: rtl/seq_accum_responder.sv
// Accumulates BEATS valid data beats per start and offers the sum on a valid/ready port.
// Define SEQ_ACCUM_SVA_EN to bind the seq_accum_responder_sva checker.
module seq_accum_responder
    import seq_accum_pkg::*;
#(
    parameter int DW    = DW_DEFAULT,
    parameter int BEATS = BEATS_DEFAULT
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          clear,
    input  logic [DW-1:0] data_in,
    input  logic          data_valid,
    output logic          busy,
    output logic          done,
    output logic [DW-1:0] result,
    output logic          result_valid,
    input  logic          result_ready
);

    localparam int             CW   = cnt_w(BEATS);
    localparam logic [CW-1:0]  LAST = CW'(BEATS - 1);

    accum_state_e  state, state_nxt;
    logic [DW-1:0] acc;
    logic [CW-1:0] cnt;
    logic          beat_last;

    assign beat_last = data_valid && (cnt == LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (start) state_nxt = ACCUM;
            ACCUM: if (beat_last) state_nxt = DONE;
            DONE:  state_nxt = HOLD;
            HOLD:  if (result_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (clear) state_nxt = IDLE;
    end

    // Datapath: wraps modulo 2^DW; result only moves on the DONE cycle so it
    // is naturally stable through HOLD.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc    <= '0;
            cnt    <= '0;
            result <= '0;
        end else if (clear) begin
            acc    <= '0;
            cnt    <= '0;
            result <= '0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    acc <= '0;
                    cnt <= '0;
                end
                ACCUM: if (data_valid) begin
                    acc <= acc + data_in;
                    cnt <= cnt + 1'b1;
                end
                DONE: result <= acc;
                default: ;
            endcase
        end
    end

    assign busy         = (state != IDLE);
    assign done         = (state == DONE);
    assign result_valid = (state == HOLD);

endmodule

`ifdef SEQ_ACCUM_SVA_EN
bind seq_accum_responder seq_accum_responder_sva #(.DW(DW), .BEATS(BEATS)) u_sva (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .clear        (clear),
    .data_in      (data_in),
    .data_valid   (data_valid),
    .busy         (busy),
    .done         (done),
    .result       (result),
    .result_valid (result_valid),
    .result_ready (result_ready)
);
`endif

// File: tb/tb_seq_accum_responder.sv
// Directed table-driven bench for seq_accum_responder (BEATS=2, DW=32 and DW=8).
module tb_seq_accum_responder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start, clear, data_valid, result_ready;
    logic [31:0] data_in;
    logic        busy, done, result_valid;
    logic [31:0] result;

    logic        s8_start, s8_clear, s8_dv, s8_ready;
    logic [7:0]  s8_data;
    logic        s8_busy, s8_done, s8_rv;
    logic [7:0]  s8_result;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    seq_accum_responder #(.DW(32), .BEATS(2)) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .clear(clear),
        .data_in(data_in), .data_valid(data_valid), .busy(busy), .done(done),
        .result(result), .result_valid(result_valid), .result_ready(result_ready)
    );

    seq_accum_responder #(.DW(8), .BEATS(2)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .start(s8_start), .clear(s8_clear),
        .data_in(s8_data), .data_valid(s8_dv), .busy(s8_busy), .done(s8_done),
        .result(s8_result), .result_valid(s8_rv), .result_ready(s8_ready)
    );

    typedef struct {
        logic        start, clear, dv, ready;
        logic [31:0] data;
        logic        busy, done, rv;
        logic [31:0] res;
        logic        chk_res;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t v(input logic st, input logic cl, input logic dv,
                               input logic [31:0] d, input logic rdy,
                               input logic b, input logic dn, input logic rv,
                               input logic [31:0] r, input logic cr);
        vec_t t;
        t.start = st; t.clear = cl; t.dv = dv; t.data = d; t.ready = rdy;
        t.busy = b; t.done = dn; t.rv = rv; t.res = r; t.chk_res = cr;
        return t;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic st, input logic cl, input logic dv,
                         input logic [31:0] d, input logic rdy);
        @(negedge clk);
        start = st; clear = cl; data_valid = dv; data_in = d; result_ready = rdy;
    endtask

    initial begin
        rst_n = 1'b0;
        start = 0; clear = 0; data_valid = 0; data_in = 0; result_ready = 0;
        s8_start = 0; s8_clear = 0; s8_dv = 0; s8_data = 0; s8_ready = 0;

        // Rows: inputs applied before an edge, outputs expected after it.
        //             st cl dv data rdy   busy done rv res  chk_res
        // basic: beats 1,1
        vecs.push_back(v(1,0,0, 0,0,  1,0,0, 0,1));
        vecs.push_back(v(0,0,1, 1,0,  1,0,0, 0,1));
        vecs.push_back(v(0,0,1, 1,0,  1,1,0, 0,1));
        vecs.push_back(v(0,0,0, 0,0,  1,0,1, 2,1));
        vecs.push_back(v(0,0,0, 0,1,  0,0,0, 2,1));
        // gapped: 5,-,-,7; ready high during DONE must not skip HOLD
        vecs.push_back(v(1,0,0, 0,0,  1,0,0, 2,1));
        vecs.push_back(v(0,0,1, 5,0,  1,0,0, 2,1));
        vecs.push_back(v(0,0,0,99,0,  1,0,0, 2,1));
        vecs.push_back(v(0,0,0,99,0,  1,0,0, 2,1));
        vecs.push_back(v(0,0,1, 7,1,  1,1,0, 2,1));
        vecs.push_back(v(0,0,0, 0,0,  1,0,1,12,1));
        vecs.push_back(v(0,0,0, 0,1,  0,0,0,12,1));
        // backpressure: 10+20, six cycles not ready
        vecs.push_back(v(1,0,0, 0,0,  1,0,0,12,1));
        vecs.push_back(v(0,0,1,10,0,  1,0,0,12,1));
        vecs.push_back(v(0,0,1,20,0,  1,1,0,12,1));
        for (int i = 0; i < 6; i++)
            vecs.push_back(v(0,0,0, 0,0,  1,0,1,30,1));
        vecs.push_back(v(0,0,0, 0,1,  0,0,0,30,1));
        // start held high throughout: one transaction, restart after accept
        vecs.push_back(v(1,0,0, 0,0,  1,0,0,30,1));
        vecs.push_back(v(1,0,1, 2,0,  1,0,0,30,1));
        vecs.push_back(v(1,0,1, 3,0,  1,1,0,30,1));
        vecs.push_back(v(1,0,0, 0,0,  1,0,1, 5,1));
        vecs.push_back(v(1,0,0, 0,0,  1,0,1, 5,1));
        vecs.push_back(v(1,0,0, 0,1,  0,0,0, 5,1));
        vecs.push_back(v(1,0,0, 0,0,  1,0,0, 5,1));
        // abort after one beat, clear beats start/data_valid, then 3+4
        vecs.push_back(v(0,0,1, 4,0,  1,0,0, 5,1));
        vecs.push_back(v(1,1,1, 9,1,  0,0,0, 0,0));
        vecs.push_back(v(1,0,0, 0,0,  1,0,0, 0,0));
        vecs.push_back(v(0,0,1, 3,0,  1,0,0, 0,0));
        vecs.push_back(v(0,0,1, 4,0,  1,1,0, 0,0));
        vecs.push_back(v(0,0,0, 0,0,  1,0,1, 7,1));
        vecs.push_back(v(0,0,0, 0,1,  0,0,0, 7,1));
        // clear in HOLD wins over ready
        vecs.push_back(v(1,0,0, 0,0,  1,0,0, 7,1));
        vecs.push_back(v(0,0,1, 1,0,  1,0,0, 7,1));
        vecs.push_back(v(0,0,1, 1,0,  1,1,0, 7,1));
        vecs.push_back(v(0,0,0, 0,0,  1,0,1, 2,1));
        vecs.push_back(v(0,1,0, 0,1,  0,0,0, 0,0));
        // refill with a nonzero sum for the reset test
        vecs.push_back(v(1,0,0, 0,0,  1,0,0, 0,0));
        vecs.push_back(v(0,0,1, 6,0,  1,0,0, 0,0));
        vecs.push_back(v(0,0,1, 6,0,  1,1,0, 0,0));
        vecs.push_back(v(0,0,0, 0,1,  1,0,1,12,1));
        vecs.push_back(v(0,0,0, 0,1,  0,0,0,12,1));

        repeat (3) @(posedge clk);
        #1;
        chk("reset_busy", {31'd0, busy}, 0);
        chk("reset_done", {31'd0, done}, 0);
        chk("reset_rv", {31'd0, result_valid}, 0);
        chk("reset_result", result, 0);
        chk("reset_result8", {24'd0, s8_result}, 0);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            drive(vecs[i].start, vecs[i].clear, vecs[i].dv, vecs[i].data, vecs[i].ready);
            @(posedge clk);
            #1;
            chk($sformatf("row%0d_busy", i), {31'd0, busy}, {31'd0, vecs[i].busy});
            chk($sformatf("row%0d_done", i), {31'd0, done}, {31'd0, vecs[i].done});
            chk($sformatf("row%0d_rv", i), {31'd0, result_valid}, {31'd0, vecs[i].rv});
            if (vecs[i].chk_res)
                chk($sformatf("row%0d_result", i), result, vecs[i].res);
        end

        // Async reset mid-ACCUM: outputs drop without waiting for an edge.
        drive(1,0,0,0,0);
        drive(0,0,1,3,0);
        @(negedge clk);
        data_valid = 0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_busy", {31'd0, busy}, 0);
        chk("arst_done", {31'd0, done}, 0);
        chk("arst_rv", {31'd0, result_valid}, 0);
        chk("arst_result", result, 0);
        @(negedge clk);
        rst_n = 1'b1;
        drive(1,0,0,0,0);
        drive(0,0,1,3,0);
        drive(0,0,1,4,0);
        @(posedge clk); #1;
        chk("post_rst_done", {31'd0, done}, 1);
        drive(0,0,0,0,0);
        @(posedge clk); #1;
        chk("post_rst_rv", {31'd0, result_valid}, 1);
        chk("post_rst_result", result, 7);
        drive(0,0,0,0,1);
        @(posedge clk); #1;
        chk("post_rst_idle", {31'd0, busy}, 0);
        drive(0,0,0,0,0);

        // DW=8 wrap: 0xF0 + 0x20 = 0x10.
        @(negedge clk); s8_start = 1;
        @(negedge clk); s8_start = 0; s8_dv = 1; s8_data = 8'hF0;
        @(negedge clk); s8_data = 8'h20;
        @(negedge clk); s8_dv = 0;
        begin
            int n;
            n = 0;
            while (!s8_rv && n < 8) begin
                @(posedge clk); #1;
                n++;
            end
            chk("wrap_rv_seen", {31'd0, s8_rv}, 1);
        end
        chk("wrap_result", {24'd0, s8_result}, 32'h10);
        @(negedge clk); s8_ready = 1;
        @(posedge clk); #1;
        chk("wrap_idle", {31'd0, s8_busy}, 0);
        s8_ready = 0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule
